// File: rtl/fm_mod_dds.sv
// fm_mod_dds: DDS FM modulator, tone accumulator -> sine LUT -> deviation scale -> carrier accumulator -> LUT -> DAC.
// Define FM_MOD_FSK_EN to add 2-FSK (square-wave tone) selected by the shadowed mode bit.
module fm_mod_dds #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 10,
  parameter int DEV_W   = 24
) (
  input  logic               clk_32m,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] fc_word,
  input  logic [PHASE_W-1:0] fm_word,
  input  logic [DEV_W-1:0]   dev_word,
  input  logic               mode,
  output logic [OUT_W-1:0]   dac_data,
  output logic               dac_valid,
  output logic               mod_sync
);

  localparam int LUT_N   = 1 << LUT_AW;
  localparam int HALF    = LUT_N / 2;
  localparam int QUARTER = LUT_N / 4;
  localparam int AMP     = (1 << (OUT_W - 1)) - 1;
  localparam int PROD_W  = OUT_W + 1 + DEV_W;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1 << (OUT_W - 1));
  localparam real PI = 3.14159265358979323846;

  // Elaboration-time sine: quarter-wave fold plus Taylor series, rounded to nearest.
  function automatic logic signed [OUT_W-1:0] sine_q(input int k);
    real x;
    real term;
    real acc;
    int  q;
    int  mag;
    q = k % HALF;
    if (q > QUARTER) q = HALF - q;
    x = PI * real'(q) / real'(HALF);
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    mag = $rtoi(real'(AMP) * acc + 0.5);
    return (k >= HALF) ? OUT_W'(-mag) : OUT_W'(mag);
  endfunction

  logic signed [OUT_W-1:0] lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic signed [OUT_W-1:0] VAL = sine_q(k);
    assign lut[k] = VAL;
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state;
  state_t state_next;
  logic   advance;
  logic   from_idle;

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (en) state_next = RUN;
    else    state_next = IDLE;
  end

  always_comb begin
    advance   = (state_next == RUN);
    from_idle = (state == IDLE);
  end

  // Config handshake: a word transfers on a clock edge with cfg_valid & cfg_ready. cfg_ready stays low
  // while the word waits in the shadow and returns high in the cycle the word becomes active.
  logic [PHASE_W-1:0] fc_shd, fm_shd, fc_act, fm_act;
  logic [DEV_W-1:0]   dev_shd, dev_act;
  logic               pending;
  logic               accept, apply, carry;
  logic [PHASE_W-1:0] mphase, mphase_sum, cphase, fword, delta;
  logic signed [OUT_W:0]    m, m_next;
  logic signed [PROD_W-1:0] prod;
  logic [2:0]         fill;

  assign cfg_ready = ~pending;
  assign accept    = cfg_valid & ~pending;
  // Retune only at a tone wrap so the modulating waveform never steps; apply at once if the tone is static.
  assign apply     = pending & (~advance | from_idle | (fm_act == '0) | carry);

  assign {carry, mphase_sum} = {1'b0, mphase} + {1'b0, fm_act};
  assign prod  = PROD_W'(m) * PROD_W'($signed({1'b0, dev_act}));
  assign delta = PHASE_W'(prod >>> (OUT_W - 1));

`ifdef FM_MOD_FSK_EN
  localparam logic signed [OUT_W:0] M_FSK = (OUT_W + 1)'(1 << (OUT_W - 1));
  logic mode_shd, mode_act;

  always_comb begin
    m_next = (OUT_W + 1)'(lut[mphase[PHASE_W-1 -: LUT_AW]]);
    if (mode_act) m_next = mphase[PHASE_W-1] ? -M_FSK : M_FSK;
  end

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      mode_shd <= 1'b0;
      mode_act <= 1'b0;
    end else begin
      if (accept) mode_shd <= mode;
      if (apply)  mode_act <= mode_shd;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    m_next = (OUT_W + 1)'(lut[mphase[PHASE_W-1 -: LUT_AW]]);
  end
`endif

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      fc_shd  <= '0;
      fm_shd  <= '0;
      dev_shd <= '0;
      fc_act  <= '0;
      fm_act  <= '0;
      dev_act <= '0;
      pending <= 1'b0;
    end else begin
      if (accept) begin
        fc_shd  <= fc_word;
        fm_shd  <= fm_word;
        dev_shd <= dev_word;
      end
      if (apply) begin
        fc_act  <= fc_shd;
        fm_act  <= fm_shd;
        dev_act <= dev_shd;
      end
      if (accept)     pending <= 1'b1;
      else if (apply) pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      mphase    <= '0;
      mod_sync  <= 1'b0;
      m         <= '0;
      fword     <= '0;
      cphase    <= '0;
      dac_data  <= MID;
      dac_valid <= 1'b0;
      fill      <= '0;
    end else if (!advance) begin
      mphase    <= '0;
      mod_sync  <= 1'b0;
      m         <= '0;
      fword     <= '0;
      cphase    <= '0;
      dac_data  <= MID;
      dac_valid <= 1'b0;
      fill      <= '0;
    end else begin
      mphase    <= mphase_sum;
      mod_sync  <= carry;
      m         <= m_next;
      fword     <= fc_act + delta;
      cphase    <= cphase + fword;
      dac_data  <= $unsigned(lut[cphase[PHASE_W-1 -: LUT_AW]]) + MID;
      fill      <= (fill == 3'd4) ? fill : fill + 3'd1;
      dac_valid <= (fill == 3'd4);
    end
  end

endmodule

// File: tb/tb_fm_mod_dds.sv
// tb_fm_mod_dds: directed + randomized checks of fm_mod_dds against a phase-sum reference model.
// Define FM_MOD_FSK_EN for both files to include the 2-FSK scenario.
module tb_fm_mod_dds;

  localparam longint unsigned MASK = 64'hFFFF_FFFF;
  localparam real PI = 3.14159265358979323846;
`ifdef FM_MOD_FSK_EN
  localparam bit FSK_BUILD = 1'b1;
`else
  localparam bit FSK_BUILD = 1'b0;
`endif

  logic        clk_32m;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] fc_word;
  logic [31:0] fm_word;
  logic [23:0] dev_word;
  logic        mode;
  logic [9:0]  dac_data;
  logic        dac_valid;
  logic        mod_sync;

  fm_mod_dds dut (
    .clk_32m   (clk_32m),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .fc_word   (fc_word),
    .fm_word   (fm_word),
    .dev_word  (dev_word),
    .mode      (mode),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .mod_sync  (mod_sync)
  );

  initial begin
    clk_32m = 1'b0;
    forever #5 clk_32m = ~clk_32m;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: active/shadow config and per-run-cycle phase histories (index = run cycle).
  longint unsigned act_fc, act_fm, act_dev, shd_fc, shd_fm, shd_dev;
  bit              act_mode, shd_mode, m_pend;
  int              t;
  longint unsigned mph_h [0:2047];
  longint unsigned cph_h [0:2047];
  longint unsigned fw_h  [0:2047];
  longint          m_h   [0:2047];
  logic [31:0]     exp_dac;
  logic            exp_valid, exp_sync;
  int              mn, mx;

  function automatic longint lut_ref(input longint unsigned ph);
    longint k;
    k = longint'(ph >> 22);
    return longint'($floor(511.0 * $sin(2.0 * PI * real'(k) / 1024.0) + 0.5));
  endfunction

  function automatic longint tone(input longint unsigned ph, input bit md);
    if (FSK_BUILD && md) return (ph >= 64'h8000_0000) ? -64'sd512 : 64'sd512;
    return lut_ref(ph);
  endfunction

  function automatic longint dterm(input longint mv, input longint unsigned dev);
    longint p;
    p = mv * longint'(dev);
    return p >>> 9;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    act_fc = 0; act_fm = 0; act_dev = 0; act_mode = 0;
    shd_fc = 0; shd_fm = 0; shd_dev = 0; shd_mode = 0;
    m_pend = 0;
    t = 0;
    mph_h[0] = 0; cph_h[0] = 0; fw_h[0] = 0; m_h[0] = 0;
  endtask

  // One clock: advance the model for this edge, then compare outputs 1 time unit later.
  task automatic step();
    bit accept, prev_idle, wrap, apply, en_s;
    longint unsigned sum, in_fc, in_fm, in_dev;
    bit in_mode;
    en_s = en;
    accept = cfg_valid && !m_pend;
    in_fc = fc_word; in_fm = fm_word; in_dev = dev_word; in_mode = mode;
    prev_idle = (t == 0);
    wrap = 1'b0;
    @(posedge clk_32m);
    if (en_s && t < 2047) begin
      t++;
      sum = mph_h[t-1] + act_fm;
      wrap = (sum > MASK);
      mph_h[t] = sum & MASK;
      m_h[t] = tone(mph_h[t-1], act_mode);
      fw_h[t] = (act_fc + longint'(dterm(m_h[t-1], act_dev))) & MASK;
      cph_h[t] = (cph_h[t-1] + fw_h[t-1]) & MASK;
      exp_dac = 32'(lut_ref(cph_h[t-1]) + 512);
      exp_valid = (t >= 5);
    end else begin
      t = 0;
      mph_h[0] = 0; cph_h[0] = 0; fw_h[0] = 0; m_h[0] = 0;
      exp_dac = 32'd512;
      exp_valid = 1'b0;
    end
    exp_sync = wrap;
    apply = m_pend && (!en_s || prev_idle || act_fm == 0 || wrap);
    if (apply) begin
      act_fc = shd_fc; act_fm = shd_fm; act_dev = shd_dev; act_mode = shd_mode;
      m_pend = 0;
    end
    if (accept) begin
      shd_fc = in_fc; shd_fm = in_fm; shd_dev = in_dev; shd_mode = in_mode;
      m_pend = 1;
    end
    #1;
    chk("dac_valid", dac_valid, exp_valid);
    chk("mod_sync", mod_sync, exp_sync);
    chk("cfg_ready", cfg_ready, !m_pend);
    if (!en_s || t >= 5) chk("dac_data", dac_data, exp_dac);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send_cfg(input longint unsigned fc, input longint unsigned fm,
                          input longint unsigned dev, input bit md);
    fc_word = 32'(fc); fm_word = 32'(fm); dev_word = 24'(dev); mode = md;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic check_idle_now(input string tag);
    chk({tag, "_dac_data"}, dac_data, 32'd512);
    chk({tag, "_dac_valid"}, dac_valid, 1'b0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    chk({tag, "_mod_sync"}, mod_sync, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    fc_word = '0; fm_word = '0; dev_word = '0; mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_32m);
    #1;
    check_idle_now("reset");
    @(negedge clk_32m);
    rst_n = 1'b1;
    run(100);

    // Pure 1 MHz carrier: period 32 samples spanning the full code range.
    send_cfg(64'd134217728, 0, 0, 1'b0);
    step();
    en = 1'b1;
    mn = 1024; mx = -1;
    repeat (80) begin
      step();
      if (t >= 5) begin
        if (int'(dac_data) < mn) mn = int'(dac_data);
        if (int'(dac_data) > mx) mx = int'(dac_data);
      end
    end
    chk("carrier_min", 32'(mn), 32'd1);
    chk("carrier_max", 32'(mx), 32'd1023);
    en = 1'b0;
    step();

    // Randomized configs with a mid-run retune; round 0 uses a static tone.
    for (int r = 0; r < 4; r++) begin
      send_cfg($urandom, (r == 0) ? 0 : $urandom_range(1 << 24, 1 << 27),
               $urandom_range(0, 24'hFFFFFF), 1'($urandom_range(0, 1)));
      step();
      en = 1'b1;
      run(60);
      send_cfg($urandom, $urandom_range(1 << 24, 1 << 27),
               $urandom_range(0, 24'hFFFFFF), 1'($urandom_range(0, 1)));
      run(200);
      en = 1'b0;
      step();
    end

    // Retune mid-tone: new carrier takes effect only at the tone wrap.
    send_cfg(64'd134217728, 64'd33554432, 64'd671089, 1'b0);
    step();
    en = 1'b1;
    run(100);
    send_cfg(64'd268435456, 64'd33554432, 64'd671089, 1'b0);
    run(200);

    // Drop en with a word pending: it is applied and cfg_ready returns.
    en = 1'b0;
    step();
    send_cfg(64'd134217728, 64'd1048576, 64'd1000, 1'b0);
    step();
    en = 1'b1;
    run(30);
    send_cfg(64'd268435456, 64'd1048576, 64'd5000, 1'b0);
    en = 1'b0;
    step();
    en = 1'b1;
    run(40);

    // Async reset mid-run with a word pending: everything clears, pending word discarded.
    send_cfg(64'd123456789, 64'd4194304, 64'd77777, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_now("async_reset");
    model_reset();
    @(posedge clk_32m);
    #2;
    rst_n = 1'b1;
    run(30);
    en = 1'b0;
    step();

`ifdef FM_MOD_FSK_EN
    send_cfg(64'd134217728, 64'd33554432, 64'd4194304, 1'b1);
    step();
    en = 1'b1;
    run(300);
    en = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
